// File: rtl/dcache1_wb_buf_if.sv
// Eviction/L2/lookup bundle for the dcache1 victim write-back buffer.
// slave = the buffer itself; master = tag ways, L2 arbiter and load lookup side.
interface dcache1_wb_buf_if #(
  parameter int PADDR_WIDTH = 44
);
  localparam int AW = PADDR_WIDTH - 7;

  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic          wb_valid;
  logic          wb_excl;
  logic          wb_stall;
  logic          l2_req;
  logic [AW-1:0] l2_addr;
  logic          l2_excl;
  logic          l2_ack;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic          flush;
  logic          busy;

  modport slave (
    input  wb_en, wb_addr, wb_valid, wb_excl, l2_ack, lk_addr, flush,
    output wb_stall, l2_req, l2_addr, l2_excl, lk_hit, busy
  );

  modport master (
    output wb_en, wb_addr, wb_valid, wb_excl, l2_ack, lk_addr, flush,
    input  wb_stall, l2_req, l2_addr, l2_excl, lk_hit, busy
  );
endinterface

// File: rtl/dcache1_wb_buf.sv
// dcache1 victim write-back buffer: queues evicted lines to L2, with in-flight lookup.
// Optional DC1_WB_MERGE_EN: evictions matching a queued, uncommitted entry merge into it.
module dcache1_wb_buf #(
  parameter int DEPTH       = 8,
  parameter int PADDR_WIDTH = 44
) (
  input logic              clk,
  input logic              rst,
  dcache1_wb_buf_if.slave  bus
);
  localparam int AW = PADDR_WIDTH - 7;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state_q, state_d;
  logic [PW:0]      head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, vld_d, excl_q, excl_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic             flush_q, flush_d;

  logic [PW:0]      count, count_d;
  logic [PW-1:0]    head_idx, tail_idx;
  logic             full, empty, pop, push, merge_hit;
  logic [DEPTH-1:0] merge_vec;

  always_comb begin
    head_idx = head_q[PW-1:0];
    tail_idx = tail_q[PW-1:0];
    empty    = (head_q == tail_q);
    full     = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);
    count    = tail_q - head_q;
  end

`ifdef DC1_WB_MERGE_EN
  // The head in REQ is already committed to L2, so it never absorbs a merge.
  always_comb begin
    merge_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == bus.wb_addr) &&
          !((state_q == REQ) && (PW'(i) == head_idx)))
        merge_vec[i] = 1'b1;
    end
  end
`else
  always_comb merge_vec = '0;
`endif

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    vld_d     = vld_q;
    excl_d    = excl_q;
    addr_d    = addr_q;
    merge_hit = |merge_vec;
    pop       = (state_q == REQ) && bus.l2_ack;
    push      = bus.wb_en && bus.wb_valid && !merge_hit && !full;

    if (bus.wb_en && bus.wb_valid && merge_hit)
      excl_d = excl_q | (merge_vec & {DEPTH{bus.wb_excl}});
    if (pop) begin
      vld_d[head_idx] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_idx]  = 1'b1;
      excl_d[tail_idx] = bus.wb_excl;
      addr_d[tail_idx] = bus.wb_addr;
      tail_d           = tail_q + 1'b1;
    end

    // Deciding on the post-edge occupancy lets a fresh entry request on the next
    // cycle and keeps l2_req asserted back-to-back across acks.
    count_d = tail_d - head_d;
    state_d = (count_d != '0) ? REQ : IDLE;
    flush_d = bus.flush | (flush_q & (count_d != '0));
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      excl_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      excl_q  <= excl_d;
      flush_q <= flush_d;
    end
  end

  always_ff @(negedge clk) begin
    addr_q <= addr_d;
  end

  always_comb begin
    bus.l2_req   = (state_q == REQ);
    bus.l2_addr  = bus.l2_req ? addr_q[head_idx] : '0;
    bus.l2_excl  = bus.l2_req & excl_q[head_idx];
    bus.wb_stall = (count >= (PW+1)'(DEPTH-1)) | flush_q;
    bus.busy     = !empty | bus.l2_req | flush_q;
    bus.lk_hit   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == bus.lk_addr))
        bus.lk_hit = 1'b1;
    end
  end

  wb_overflow: assert property (@(negedge clk) disable iff (rst)
                                !(bus.wb_en && full && !merge_hit))
    else $error("dcache1_wb_buf: wb_en asserted while full, eviction dropped");

endmodule

// File: tb/tb_dcache1_wb_buf.sv
// Bench for dcache1_wb_buf: directed scenarios then randomized traffic, against a queue model.
module tb_dcache1_wb_buf;
  localparam int DEPTH       = 8;
  localparam int PADDR_WIDTH = 44;
  localparam int AW          = PADDR_WIDTH - 7;

  logic clk = 1'b0;
  logic rst;

  dcache1_wb_buf_if #(.PADDR_WIDTH(PADDR_WIDTH)) bus ();

  dcache1_wb_buf #(.DEPTH(DEPTH), .PADDR_WIDTH(PADDR_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          excl;
  } ent_t;

  ent_t q[$];
  bit   m_req;
  bit   m_flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: a FIFO of outstanding victims; the head is on L2 whenever the FIFO is non-empty.
  function automatic void model_edge();
    bit pop;
    bit merged;
    int pre;
    if (rst) begin
      q.delete();
      m_req   = 1'b0;
      m_flush = 1'b0;
      return;
    end
    pop    = m_req && bus.l2_ack;
    pre    = q.size();
    merged = 1'b0;
    if (bus.wb_en && bus.wb_valid) begin
`ifdef DC1_WB_MERGE_EN
      for (int i = (m_req ? 1 : 0); i < q.size(); i++) begin
        if (q[i].addr == bus.wb_addr) begin
          q[i].excl = q[i].excl | bus.wb_excl;
          merged    = 1'b1;
        end
      end
`endif
      if (!merged && pre < DEPTH) q.push_back('{addr: bus.wb_addr, excl: bus.wb_excl});
    end
    if (pop) void'(q.pop_front());
    m_req   = (q.size() != 0);
    m_flush = bus.flush || (m_flush && q.size() != 0);
  endfunction

  function automatic bit m_hit(logic [AW-1:0] a);
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return (q.size() >= DEPTH - 1) || m_flush;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    logic [AW-1:0] ea;
    logic          ee;
    ea = '0;
    ee = 1'b0;
    if (m_req && q.size() != 0) begin
      ea = q[0].addr;
      ee = q[0].excl;
    end
    chk("l2_req",   64'(bus.l2_req),   64'(m_req));
    chk("l2_addr",  64'(bus.l2_addr),  64'(ea));
    chk("l2_excl",  64'(bus.l2_excl),  64'(ee));
    chk("wb_stall", 64'(bus.wb_stall), 64'(m_stall()));
    chk("busy",     64'(bus.busy),     64'((q.size() != 0) || m_req || m_flush));
    chk("lk_hit",   64'(bus.lk_hit),   64'(m_hit(bus.lk_addr)));
  endtask

  task automatic cyc();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    bus.wb_en    = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_excl  = 1'b0;
    bus.wb_addr  = '0;
    bus.l2_ack   = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic enq(logic [AW-1:0] a, logic e);
    bus.wb_en    = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_excl  = e;
    cyc();
    bus.wb_en    = 1'b0;
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [AW-1:0] a, b, c, x;
    int            nreq;
    int            ack_pct;
    logic [AW-1:0] seen_addr [$];
    logic          seen_excl [$];

    rst = 1'b1;
    idle_in();
    bus.lk_addr = '0;
    repeat (2) cyc();
    chk("reset_req",   64'(bus.l2_req),   64'(0));
    chk("reset_stall", 64'(bus.wb_stall), 64'(0));
    rst = 1'b0;
    cyc();

    // Single eviction then ack.
    a = AW'(37'h0_1234_5678);
    enq(a, 1'b1);
    chk("t1_req",  64'(bus.l2_req),  64'(1));
    chk("t1_addr", 64'(bus.l2_addr), 64'(a));
    chk("t1_excl", 64'(bus.l2_excl), 64'(1));
    bus.l2_ack = 1'b1;
    cyc();
    bus.l2_ack = 1'b0;
    chk("t1_req_drop", 64'(bus.l2_req), 64'(0));
    chk("t1_busy",     64'(bus.busy),   64'(0));

    // Invalid victim is dropped.
    bus.wb_en    = 1'b1;
    bus.wb_valid = 1'b0;
    bus.wb_addr  = AW'(37'h1_dead_beef);
    cyc();
    bus.wb_en = 1'b0;
    cyc();
    chk("t2_req",  64'(bus.l2_req), 64'(0));
    chk("t2_busy", 64'(bus.busy),   64'(0));

    // Fill to the stall threshold, then drain in order.
    for (int i = 0; i < 7; i++) enq(AW'(37'h100 + 3 * i), 1'(i));
    chk("t3_stall_at7", 64'(bus.wb_stall), 64'(1));
    for (int i = 0; i < 7; i++) begin
      chk("t3_order", 64'(bus.l2_addr), 64'(AW'(37'h100 + 3 * i)));
      bus.l2_ack = 1'b1;
      cyc();
      if (i == 0) chk("t3_stall_drop", 64'(bus.wb_stall), 64'(0));
    end
    bus.l2_ack = 1'b0;
    cyc();
    chk("t3_empty", 64'(bus.busy), 64'(0));

    // Lookup across pops.
    a = AW'(37'h0_aaaa_0000);
    b = AW'(37'h0_bbbb_0000);
    c = AW'(37'h0_cccc_0000);
    enq(a, 1'b0);
    bus.lk_addr = b;
    #1 chk("t4_hit_b_pre", 64'(bus.lk_hit), 64'(0));
    enq(b, 1'b0);
    chk("t4_hit_b", 64'(bus.lk_hit), 64'(1));
    bus.l2_ack = 1'b1;
    cyc();
    chk("t4_hit_b_after_a", 64'(bus.lk_hit), 64'(1));
    cyc();
    bus.l2_ack = 1'b0;
    chk("t4_hit_b_gone", 64'(bus.lk_hit), 64'(0));
    bus.lk_addr = c;
    #1 chk("t4_hit_c", 64'(bus.lk_hit), 64'(0));

    // Asynchronous reset mid-request.
    enq(a, 1'b1);
    enq(b, 1'b0);
    enq(c, 1'b1);
    bus.lk_addr = b;
    #2 rst = 1'b1;
    #1;
    chk("t5_req",  64'(bus.l2_req),  64'(0));
    chk("t5_busy", 64'(bus.busy),    64'(0));
    chk("t5_addr", 64'(bus.l2_addr), 64'(0));
    chk("t5_hit",  64'(bus.lk_hit),  64'(0));
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("t5_no_replay", 64'(bus.l2_req), 64'(0));

    // Flush forces stall until drained.
    enq(a, 1'b0);
    enq(b, 1'b0);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("t6_stall", 64'(bus.wb_stall), 64'(1));
    bus.l2_ack = 1'b1;
    cyc();
    cyc();
    bus.l2_ack = 1'b0;
    chk("t6_busy_clear", 64'(bus.busy), 64'(0));

    // Duplicate victims behind a committed head X.
    x = AW'(37'h0_0000_0777);
    enq(x, 1'b0);
    enq(a, 1'b0);
    enq(b, 1'b0);
    enq(a, 1'b1);
    nreq = 0;
    bus.l2_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!bus.l2_req) break;
      seen_addr.push_back(bus.l2_addr);
      seen_excl.push_back(bus.l2_excl);
      nreq++;
      cyc();
    end
    bus.l2_ack = 1'b0;
`ifdef DC1_WB_MERGE_EN
    chk("t7_nreq", 64'(nreq), 64'(3));
    if (nreq == 3) begin
      chk("t7_a_addr", 64'(seen_addr[1]), 64'(a));
      chk("t7_a_excl", 64'(seen_excl[1]), 64'(1));
      chk("t7_b_addr", 64'(seen_addr[2]), 64'(b));
    end
`else
    chk("t7_nreq", 64'(nreq), 64'(4));
    if (nreq == 4) begin
      chk("t7_a0_excl", 64'(seen_excl[1]), 64'(0));
      chk("t7_b_addr",  64'(seen_addr[2]), 64'(b));
      chk("t7_a1_addr", 64'(seen_addr[3]), 64'(a));
      chk("t7_a1_excl", 64'(seen_excl[3]), 64'(1));
    end
`endif
    cyc();

    // Randomized traffic with alternating ack pressure.
    for (int n = 0; n < 800; n++) begin
      ack_pct      = ((n / 100) % 2 == 0) ? 20 : 75;
      rst          = ($urandom_range(0, 199) == 0);
      bus.wb_en    = !m_stall() && ($urandom_range(0, 1) == 1);
      bus.wb_valid = ($urandom_range(0, 3) != 0);
      bus.wb_excl  = 1'($urandom_range(0, 1));
      bus.wb_addr  = AW'(37'h2000 + $urandom_range(0, 11));
      bus.l2_ack   = ($urandom_range(0, 99) < ack_pct);
      bus.flush    = ($urandom_range(0, 59) == 0);
      bus.lk_addr  = AW'(37'h2000 + $urandom_range(0, 13));
      cyc();
    end
    rst = 1'b0;
    idle_in();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
